// File: rtl/full_hk_pkg.sv
// Shared types and constants for the full-handshake CDC blocks.
// FULL_HK_RD_SYNC3_EN selects a 3-flop request synchronizer instead of 2.
package full_hk_pkg;

  localparam int HK_DATA_W = 32;
  localparam int HK_CNT_W  = 16;

`ifdef FULL_HK_RD_SYNC3_EN
  localparam int HK_SYNC_STAGES = 3;
`else
  localparam int HK_SYNC_STAGES = 2;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hk_rd_state_t;

endpackage

// File: rtl/full_hk_sync.sv
// N-stage single-bit synchronizer, async active-high reset to 0.
module full_hk_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/full_hk_rclk.sv
// Read-domain end of the four-phase full handshake: capture held wr_data into
// a one-entry output buffer and ack. FULL_HK_RD_SYNC3_EN deepens the wr_vld sync.
module full_hk_rclk
  import full_hk_pkg::*;
#(
  parameter int DATA_W = HK_DATA_W,
  parameter int CNT_W  = HK_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_ack,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic              vld_s;
  logic              capture;
  logic              consume;
  hk_rd_state_t      state_q, state_d;
  logic              rd_ack_q, rd_ack_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;

  full_hk_sync #(.STAGES(HK_SYNC_STAGES)) u_vld_sync (
    .clk (clk),
    .rst (rst),
    .d   (wr_vld),
    .q   (vld_s)
  );

  assign consume = out_vld_q & out_rdy;
  // Only capture into a free (or freeing) buffer; otherwise withhold the ack.
  assign capture = (state_q == IDLE) & vld_s & (~out_vld_q | out_rdy);

  always_comb begin
    state_d    = state_q;
    rd_ack_d   = rd_ack_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    xfer_cnt_d = xfer_cnt_q;
    if (consume) out_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          out_data_d = wr_data;
          out_vld_d  = 1'b1;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          rd_ack_d   = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (!vld_s) begin
          rd_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        rd_ack_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ack_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ack_q   <= rd_ack_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign rd_ack   = rd_ack_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_full_hk_rclk.sv
// Bench for full_hk_rclk: directed latency/backpressure/reset cases plus a
// randomized four-phase writer and downstream consumer with an in-order queue.
module tb_full_hk_rclk;

  localparam int DW = 32;
  localparam int CW = 4;
`ifdef FULL_HK_RD_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int NRAND = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_vld = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          out_rdy = 1'b0;
  logic          rd_ack, out_vld;
  logic [DW-1:0] out_data;
  logic [CW-1:0] xfer_cnt;

  int n_vec = 0;
  int n_err = 0;
  int delivered;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  full_hk_rclk #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .rd_ack   (rd_ack),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .xfer_cnt (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; wr_vld = 1'b0; wr_data = '0; out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Four-phase writer: hold data until ack seen, then drop and scramble the bus.
  task automatic send(input logic [DW-1:0] w);
    int t;
    wr_data = w; wr_vld = 1'b1;
    exp_q.push_back(w);
    t = 0;
    while (rd_ack !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk("ack_rise", 32'(rd_ack), 32'd1);
    wr_vld = 1'b0; wr_data = $urandom;
    t = 0;
    while (rd_ack !== 1'b0 && t < 300) begin @(negedge clk); t++; end
    chk("ack_fall", 32'(rd_ack), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);

    // Single transfer: exact request and release latency
    do_reset;
    out_rdy = 1'b1; wr_data = 32'hDEADBEEF; wr_vld = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk("lat_ack", 32'(rd_ack), 32'(i == LAT));
      chk("lat_vld", 32'(out_vld), 32'(i == LAT));
    end
    chk("lat_data", out_data, 32'hDEADBEEF);
    wr_vld = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      chk("fall_ack", 32'(rd_ack), 32'(i < LAT));
    end
    chk("single_cnt", 32'(xfer_cnt), 32'd1);

    // Backpressure: second request stalls until consumer frees the buffer
    do_reset;
    exp_q.delete();
    send(32'h1);
    wr_data = 32'h2; wr_vld = 1'b1;
    step(LAT + 4);
    chk("bp_stall_ack", 32'(rd_ack), 32'd0);
    chk("bp_hold_data", out_data, 32'h1);
    chk("bp_hold_vld", 32'(out_vld), 32'd1);
    out_rdy = 1'b1;
    step(1);
    chk("bp_swap_data", out_data, 32'h2);
    chk("bp_swap_vld", 32'(out_vld), 32'd1);
    chk("bp_swap_ack", 32'(rd_ack), 32'd1);
    chk("bp_cnt", 32'(xfer_cnt), 32'd2);
    out_rdy = 1'b0; wr_vld = 1'b0;
    step(LAT + 1);
    chk("bp_ack_low", 32'(rd_ack), 32'd0);

    // Reset while acking, request still held through release
    do_reset;
    wr_data = 32'hA5A5A5A5; wr_vld = 1'b1;
    begin
      int t = 0;
      while (rd_ack !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    end
    chk("mid_ack_up", 32'(rd_ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(rd_ack), 32'd0);
    chk("mid_rst_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    wr_data = 32'h12345678;
    @(negedge clk);
    rst = 1'b0;
    step(LAT - 1);
    chk("post_rst_early", 32'(rd_ack), 32'd0);
    step(1);
    chk("post_rst_ack", 32'(rd_ack), 32'd1);
    chk("post_rst_data", out_data, 32'h12345678);
    chk("post_rst_cnt", 32'(xfer_cnt), 32'd1);
    wr_vld = 1'b0;
    step(LAT + 1);

    // Random traffic with random backpressure; wraps the 4-bit counter
    do_reset;
    exp_q.delete();
    delivered = 0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          send($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        int cyc = 0;
        while (delivered < NRAND && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          out_rdy = 1'($urandom_range(0, 1));
          if (out_vld && out_rdy) begin
            chk("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("word", out_data, exp_q.pop_front());
            delivered++;
          end
        end
      end
    join
    out_rdy = 1'b0;
    step(2);
    chk("delivered", 32'(delivered), 32'(NRAND));
    chk("wrap_cnt", 32'(xfer_cnt), 32'(NRAND % 16));
    chk("q_drained", 32'(exp_q.size()), 32'd0);
    chk("final_vld", 32'(out_vld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_hk_rclk.md
# full_hk_rclk

Read-clock-domain end of the four-phase full-handshake CDC. Synchronizes the incoming `wr_vld` request and captures the held `wr_data` bus into a local output register. It then drives `rd_ack` back to the write domain and presents the word to a downstream valid/ready consumer. It pairs with the write-clock-domain handshake block; together they carry one multi-bit word per complete four-phase cycle.

## Interface
- `DATA_W`, 32, width of the transferred word
- `CNT_W`, 16, width of the transfer counter
- `clk`  in  1  read-domain clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `wr_vld`  in  1  request from write domain, asynchronous to `clk`
- `wr_data`  in  DATA_W  word from write domain; asynchronous, stable while `wr_vld`=1 and until `rd_ack` is seen by the writer
- `rd_ack`  out  1  acknowledge to write domain, registered
- `out_vld`  out  1  output register holds a word
- `out_data`  out  DATA_W  captured word, registered
- `out_rdy`  in  1  downstream accepts `out_data` when `out_vld`&`out_rdy`
- `xfer_cnt`  out  CNT_W  count of captured words, wraps

## Operation
- `wr_vld` passes through a synchronizer to give `vld_s`. The depth is 2 flops by default (see Configuration). `wr_data` is never synchronized; it is sampled only when `vld_s`=1.
- Output buffer is one entry: `out_vld`/`out_data`. The entry is freed on `out_vld`&`out_rdy`.
- FSM states: IDLE, ACK.
  - IDLE, `rd_ack`=0. When `vld_s`=1 and the buffer is free or is being freed this cycle: load `out_data`←`wr_data`, set `out_vld`=1, increment `xfer_cnt`, set `rd_ack`=1, go to ACK.
  - IDLE with `vld_s`=1 and the buffer occupied and not consumed: stay in IDLE, hold `rd_ack`=0 (backpressure to the writer).
  - ACK, `rd_ack`=1. When `vld_s`=0: clear `rd_ack`, go to IDLE. Otherwise stay.
- Capture and consume in the same cycle (buffer full, `out_rdy`=1, capture condition true): the new word replaces the old one, and `out_vld` stays 1.
- A new capture is possible only after returning to IDLE, so one `wr_vld` pulse yields exactly one word.
- `xfer_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- Reset mid-operation: all state clears. If `wr_vld` is still high after reset release, it is captured as a new transfer. The system reset must cover both domains.
- Downstream `out_data` is stable while `out_vld`=1 and `out_rdy`=0.

## Timing
- Reset values: `rd_ack`=0, `out_vld`=0, `out_data`=0, `xfer_cnt`=0. The FSM resets to IDLE and all synchronizer flops to 0.
- `wr_vld` is first sampled high at edge E0:
  - `vld_s`=1 after edge E1 (2-stage).
  - Capture at edge E2: `out_vld`, `rd_ack` and `out_data` are valid after E2.
- `wr_vld` is first sampled low at edge F0: `rd_ack` falls after edge F2.
- Latency from sampling `wr_vld` to `rd_ack` or `out_vld`: 3 edges (2-stage), 4 edges (3-stage).
- A minimum full cycle in this domain is 6 edges, plus the writer-side synchronizer delays.
- `out_vld` falls on the edge where `out_vld`&`out_rdy`, unless a capture occurs on that edge.

## Configuration
- `FULL_HK_RD_SYNC3_EN`
  - Defined: the `wr_vld` synchronizer is 3 flops, for high-MTBF / fast-clock targets. Every request-path latency above grows by one edge.
  - Undefined: 2 flops. Ack timing relative to `vld_s` is unchanged in both cases.

## Structure
- Package `full_hk_pkg`:
  - FSM enum `hk_rd_state_t` {IDLE, ACK}.
  - Constant `HK_SYNC_STAGES`, selected by `FULL_HK_RD_SYNC3_EN`.
  - Default `DATA_W`/`CNT_W` constants.
- Sub-module `full_hk_sync`: parameterized N-stage single-bit synchronizer with async active-high reset to 0. It is shared with the write-side block for `rd_ack`.

## Test plan
- Single transfer: `wr_data`=32'hDEADBEEF, `wr_vld`=1, `out_rdy`=1. Expect `rd_ack`=1 and `out_vld`=1 with `out_data`=32'hDEADBEEF three edges after `wr_vld` is sampled. Drop `wr_vld`; expect `rd_ack`=0 three edges later, `xfer_cnt`=1.
- Backpressure: `out_rdy`=0, two back-to-back transfers 0x1 then 0x2.
  - Expect the second request to stall with `rd_ack`=0 while `out_data`=0x1 holds.
  - Raise `out_rdy`; expect 0x2 captured on the consume edge, `out_vld` continuous.
- Reset mid-ACK: assert `rst` while `rd_ack`=1. Expect all outputs 0 immediately (async). Release with `wr_vld`=1; expect a fresh capture, `xfer_cnt`=1.
- Counter wrap: with CNT_W=4, run 17 transfers. Expect `xfer_cnt`=1 and every word delivered in order.
- `FULL_HK_RD_SYNC3_EN` defined: repeat the single-transfer test. Expect `rd_ack`/`out_vld` four edges after sampling, and `rd_ack` fall four edges after `wr_vld` drops.
- Paired with the write-side block on async clocks (ratio 3:7): 1000 random words arrive in order with no duplicates or losses. `rd_ack` never rises while `wr_vld`=0 is synchronized.
